// File: rtl/tristate_bus_arbiter_if.sv
// Request/grant/data bundle shared between the requesters and the
// tristate bus arbiter.
interface tristate_bus_arbiter_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4
);
  localparam int OW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]       req;
  logic [NUM_CH*WIDTH-1:0] din;
  logic [NUM_CH-1:0]       gnt;
  logic [OW-1:0]           owner;
  logic                    bus_busy;
  logic [WIDTH-1:0]        dout;

  modport master (
    output req, din,
    input  gnt, owner, bus_busy, dout
  );

  modport slave (
    input  req, din,
    output gnt, owner, bus_busy, dout
  );
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus, with a high-Z
// turnaround gap between successive owners.
module tristate_bus_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NUM_CH     = 4,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tristate_bus_arbiter_if.slave bus_if,
  inout  wire  [WIDTH-1:0]      bus
);
  localparam int OW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OW1 = OW + 1;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [7:0]        hold_q, hold_d;
  logic [3:0]        turn_q, turn_d;
  logic [WIDTH-1:0]  dout_q;
  logic [OW-1:0]     win;
  logic [OW1-1:0]    idx;
  logic              hit, busy, others, rel;

  // Lowest offset from the pointer wins, so scan downward.
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = OW1'(ptr_q) + OW1'(i);
      if (idx >= OW1'(NUM_CH)) idx = idx - OW1'(NUM_CH);
      if (bus_if.req[idx[OW-1:0]]) begin
        win = idx[OW-1:0];
        hit = 1'b1;
      end
    end
  end

  assign busy   = |gnt_q;
  assign others = |(bus_if.req & ~gnt_q);
  assign rel    = !bus_if.req[owner_q] ||
                  ((hold_q == 8'(MAX_HOLD - 1)) && others);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          gnt_d   = NUM_CH'(1) << win;
          owner_d = win;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (hold_q != 8'(MAX_HOLD - 1)) hold_d = hold_q + 8'd1;
        if (rel) begin
          gnt_d   = '0;
          ptr_d   = (owner_q == OW'(NUM_CH - 1)) ? '0
                                                 : owner_q + 1'b1;
          turn_d  = '0;
          state_d = TURN;
        end
      end
      TURN: begin
        turn_d = turn_q + 4'd1;
        if (turn_q == 4'(TURNAROUND - 1)) begin
          if (hit) begin
            gnt_d   = NUM_CH'(1) << win;
            owner_d = win;
            hold_d  = '0;
            state_d = GRANT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  // Only sample while driven so Z never reaches dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (busy) begin
      dout_q <= bus;
    end
  end

  assign bus = busy ? bus_if.din[owner_q*WIDTH +: WIDTH]
                    : {WIDTH{1'bz}};

  assign bus_if.gnt      = gnt_q;
  assign bus_if.owner    = owner_q;
  assign bus_if.bus_busy = busy;
  assign bus_if.dout     = dout_q;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Two arbiters (short and long turnaround/hold) driven in lockstep
// and compared against an owner/age/gap reference model.
module tb_tristate_bus_arbiter;
  localparam int NC = 4;
  localparam int W  = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] req   = '0;
  logic [NC*W-1:0] din = '0;
  wire  [W-1:0]  bus0;
  wire  [W-1:0]  bus1;

  pullup pu0 (bus0);
  pullup pu1 (bus1);

  tristate_bus_arbiter_if #(.WIDTH(W), .NUM_CH(NC)) bif0 ();
  tristate_bus_arbiter_if #(.WIDTH(W), .NUM_CH(NC)) bif1 ();

  assign bif0.req = req;
  assign bif0.din = din;
  assign bif1.req = req;
  assign bif1.din = din;

  tristate_bus_arbiter #(
    .WIDTH(W), .NUM_CH(NC), .TURNAROUND(1), .MAX_HOLD(4)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .bus_if(bif0), .bus(bus0)
  );

  tristate_bus_arbiter #(
    .WIDTH(W), .NUM_CH(NC), .TURNAROUND(3), .MAX_HOLD(16)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus_if(bif1), .bus(bus1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int         m_cur [2];
  int         m_age [2];
  int         m_gap [2];
  int         m_ptr [2];
  logic [W-1:0] m_dout [2];

  function automatic int ta(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int mh(int d);
    return (d == 0) ? 4 : 16;
  endfunction

  function automatic logic [NC-1:0] gnt_of(int d);
    return (d == 0) ? bif0.gnt : bif1.gnt;
  endfunction

  function automatic logic [22:0] obs(int d);
    logic [3:0] g;
    logic       b;
    logic [1:0] o;
    logic [7:0] bs;
    logic [7:0] dq;
    if (d == 0) begin
      g = bif0.gnt; b = bif0.bus_busy; o = bif0.owner;
      bs = bus0; dq = bif0.dout;
    end else begin
      g = bif1.gnt; b = bif1.bus_busy; o = bif1.owner;
      bs = bus1; dq = bif1.dout;
    end
    return {g, b, (b === 1'b1) ? o : 2'd0, bs, dq};
  endfunction

  // Undriven bus reads as the pull-up value.
  function automatic logic [22:0] expv(int d);
    logic [3:0] g  = '0;
    logic [7:0] bs = 8'hFF;
    logic [1:0] o  = '0;
    logic       b  = 1'b0;
    if (m_cur[d] >= 0) begin
      g[m_cur[d]] = 1'b1;
      bs = din[m_cur[d]*W +: W];
      o  = 2'(m_cur[d]);
      b  = 1'b1;
    end
    return {g, b, o, bs, m_dout[d]};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cur[d] = -1; m_age[d] = 0; m_gap[d] = 0;
      m_ptr[d] = 0;  m_dout[d] = '0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) return;
    for (int d = 0; d < 2; d++) begin
      if (m_cur[d] >= 0) begin
        int  cc  = m_cur[d];
        bit  oth = (req & ~(4'b0001 << cc)) != '0;
        m_dout[d] = din[cc*W +: W];
        if (!req[cc] || (m_age[d] >= mh(d) && oth)) begin
          m_ptr[d] = (cc + 1) % NC;
          m_cur[d] = -1;
          m_gap[d] = ta(d);
        end else begin
          m_age[d]++;
        end
      end else if (m_gap[d] > 1) begin
        m_gap[d]--;
      end else begin
        m_gap[d] = 0;
        for (int k = 0; k < NC; k++) begin
          int cc = (m_ptr[d] + k) % NC;
          if (m_cur[d] < 0 && req[cc]) begin
            m_cur[d] = cc;
            m_age[d] = 1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs(d) !== expv(d)) begin
        bad++;
        $display("FAIL reset d%0d got=%h exp=%h", d, obs(d), expv(d));
      end
    end
    total++;
    if (bif0.owner !== 2'd0 || bif1.owner !== 2'd0) begin
      bad++;
      $display("FAIL reset_owner got=%0d/%0d exp=0", bif0.owner, bif1.owner);
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0001;
    din[7:0] = 8'hA5;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) req = '0;
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d)) begin
          bad++;
          $display("FAIL single d%0d c%0d got=%h exp=%h", d, c, obs(d), expv(d));
        end
      end
      if (c == 0) begin
        total++;
        if (bif0.gnt !== 4'b0001 || bus0 !== 8'hA5) begin
          bad++;
          $display("FAIL single_lat got gnt=%b bus=%h exp gnt=0001 bus=a5", bif0.gnt, bus0);
        end
      end
      if (c == 1) begin
        total++;
        if (bif0.dout !== 8'hA5) begin
          bad++;
          $display("FAIL single_dout got=%h exp=a5", bif0.dout);
        end
      end
    end
  endtask

  task automatic test_pair();
    req = 4'b1010;
    din = $urandom;
    for (int c = 0; c < 14; c++) begin
      if (c == 5) req = 4'b1000;
      if (c == 9) req = '0;
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d)) begin
          bad++;
          $display("FAIL pair d%0d c%0d got=%h exp=%h", d, c, obs(d), expv(d));
        end
      end
      if (c == 0) begin
        total++;
        if (bif0.gnt !== 4'b0010 || bif1.gnt !== 4'b0010) begin
          bad++;
          $display("FAIL pair_first got=%b/%b exp=0010", bif0.gnt, bif1.gnt);
        end
      end
    end
  endtask

  task automatic test_rotate();
    int q[$];
    logic [NC-1:0] prev = '0;
    req = 4'b1111;
    for (int c = 0; c < 30; c++) begin
      din = {$urandom};
      if (c == 26) req = '0;
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d) || !$onehot0(gnt_of(d))) begin
          bad++;
          $display("FAIL rotate d%0d c%0d got=%h exp=%h", d, c, obs(d), expv(d));
        end
      end
      if (prev == '0 && bif0.gnt != '0) q.push_back(int'(bif0.owner));
      prev = bif0.gnt;
    end
    for (int c = 0; c < 6; c++) tick();
    total++;
    if (q.size() < 5) begin
      bad++;
      $display("FAIL rotate_count got=%0d exp>=5", q.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        total++;
        if (q[i] != (q[i-1] + 1) % NC) begin
          bad++;
          $display("FAIL rotate_order i%0d got=%0d exp=%0d", i, q[i], (q[i-1] + 1) % NC);
        end
      end
    end
  endtask

  task automatic test_turn();
    int gaps [2] = '{0, 0};
    bit seen [2] = '{0, 0};
    req = 4'b0001;
    din = {$urandom};
    repeat (4) tick();
    req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d)) begin
          bad++;
          $display("FAIL turn d%0d c%0d got=%h exp=%h", d, c, obs(d), expv(d));
        end
        if (!seen[d]) begin
          if (gnt_of(d) == '0) gaps[d]++;
          else begin
            seen[d] = 1'b1;
            total++;
            if (gnt_of(d) !== 4'b0100) begin
              bad++;
              $display("FAIL turn_next d%0d got=%b exp=0100", d, gnt_of(d));
            end
          end
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      total++;
      if (gaps[d] != ta(d) || !seen[d]) begin
        bad++;
        $display("FAIL turn_gap d%0d got=%0d exp=%0d", d, gaps[d], ta(d));
      end
    end
    req = '0;
    repeat (6) tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0001;
    din = {$urandom};
    repeat (3) tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs(d) !== expv(d)) begin
        bad++;
        $display("FAIL async_rst d%0d got=%h exp=%h", d, obs(d), expv(d));
      end
    end
    @(negedge clk);
    #3 rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      total++;
      if (gnt_of(d) !== 4'b0001 || obs(d) !== expv(d)) begin
        bad++;
        $display("FAIL async_regrant d%0d got=%h exp=%h", d, obs(d), expv(d));
      end
    end
    req = '0;
    repeat (6) tick();
  endtask

  task automatic test_hold();
    req = 4'b0100;
    for (int c = 0; c < 50; c++) begin
      tick();
      din = {$urandom};
      #1;
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d) || gnt_of(d) !== 4'b0100) begin
          bad++;
          $display("FAIL hold d%0d c%0d got=%h exp=%h", d, c, obs(d), expv(d));
        end
      end
    end
    req = '0;
    @(negedge clk);
    repeat (6) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      din = {$urandom};
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (obs(d) !== expv(d) || !$onehot0(gnt_of(d))) begin
          bad++;
          $display("FAIL random d%0d c%0d got=%h exp=%h", d, c, obs(d), expv(d));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_rotate();
    test_turn();
    test_async_reset();
    test_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
